// File: rtl/bist_march_engine.sv
// March-test datapath: steps RAM address/write data per background pattern and compares read-back.
// Optional BIST_FAIL_ADDR_EN builds a register capturing the address of the first mismatch.
module bist_march_engine #(
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned NUM_PAT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rst_count,
    input  logic              rst_pat,
    input  logic              nxt_count,
    input  logic              nxt_pat,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              count_end,
    output logic              pat_end,
    output logic              error,
    output logic [ADDR_W-1:0] fail_addr
);

    localparam logic [ADDR_W:0] CntMax  = '1;
    localparam logic [2:0]      PatLast = 3'(NUM_PAT);

    logic [ADDR_W:0]   cnt_q;
    logic              done_q;
    logic              rd_vld_q;
    logic [DATA_W-1:0] exp_q;
    logic              last_q;
    logic              count_end_q;
    logic [2:0]        pat_q;
    logic              error_q;

    logic              phase;
    logic              rd_step;
    logic              mismatch;
    logic [DATA_W-1:0] bg;

    assign phase     = cnt_q[ADDR_W];
    assign ram_addr  = cnt_q[ADDR_W-1:0];
    assign ram_we    = nxt_count & ~phase & ~done_q & ~rst;
    assign rd_step   = nxt_count & phase & ~done_q & ~rst_count;
    assign mismatch  = rd_vld_q & (ram_rdata != exp_q);
    assign ram_wdata = bg;
    assign count_end = count_end_q;
    assign pat_end   = (pat_q == PatLast);
    assign error     = error_q;

    // Checkerboard flips phase with the address LSB so neighbours always differ.
    always_comb begin
        bg = '0;
        case (pat_q)
            3'd1: bg = '1;
            3'd2: begin
                for (int i = 0; i < int'(DATA_W); i++) begin
                    bg[i] = (i % 2 == 0) ^ ram_addr[0];
                end
            end
            3'd3: bg = DATA_W'(ram_addr);
            default: bg = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            done_q      <= 1'b0;
            rd_vld_q    <= 1'b0;
            exp_q       <= '0;
            last_q      <= 1'b0;
            count_end_q <= 1'b0;
            pat_q       <= '0;
            error_q     <= 1'b0;
        end else begin
            if (rst_count) begin
                cnt_q  <= '0;
                done_q <= 1'b0;
            end else if (nxt_count && !done_q) begin
                if (cnt_q == CntMax) begin
                    done_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end

            rd_vld_q <= rd_step;
            if (rd_step) begin
                exp_q <= bg;
            end
            // count_end lines up with the final compare landing on error
            last_q      <= rd_step && (cnt_q == CntMax);
            count_end_q <= last_q;

            if (rst_pat) begin
                pat_q <= '0;
            end else if (nxt_pat && (pat_q < PatLast)) begin
                pat_q <= pat_q + 1'b1;
            end

            if (rst_pat) begin
                error_q <= 1'b0;
            end else if (mismatch) begin
                error_q <= 1'b1;
            end
        end
    end

`ifdef BIST_FAIL_ADDR_EN
    logic [ADDR_W-1:0] rd_addr_q;
    logic [ADDR_W-1:0] fail_addr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr_q   <= '0;
            fail_addr_q <= '0;
        end else begin
            if (rd_step) begin
                rd_addr_q <= ram_addr;
            end
            if (rst_pat) begin
                fail_addr_q <= '0;
            end else if (mismatch && !error_q) begin
                fail_addr_q <= rd_addr_q;
            end
        end
    end

    assign fail_addr = fail_addr_q;
`else
    assign fail_addr = '0;
`endif

endmodule

// File: tb/tb_bist_march_engine.sv
// Bench for bist_march_engine: directed scenarios then random control traffic against a step-level model.
module tb_bist_march_engine;

    localparam int AW    = 2;
    localparam int DW    = 8;
    localparam int NP    = 4;
    localparam int STEPS = 8;
`ifdef BIST_FAIL_ADDR_EN
    localparam bit FA_EN = 1'b1;
`else
    localparam bit FA_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, rst_count, rst_pat, nxt_count, nxt_pat;
    logic [AW-1:0] ram_addr, fail_addr;
    logic [DW-1:0] ram_wdata, ram_rdata;
    logic          ram_we, count_end, pat_end, error;

    always #5 clk = ~clk;

    bist_march_engine #(.ADDR_W(AW), .DATA_W(DW), .NUM_PAT(NP)) dut (
        .clk       (clk),
        .rst       (rst),
        .rst_count (rst_count),
        .rst_pat   (rst_pat),
        .nxt_count (nxt_count),
        .nxt_pat   (nxt_pat),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .ram_rdata (ram_rdata),
        .count_end (count_end),
        .pat_end   (pat_end),
        .error     (error),
        .fail_addr (fail_addr)
    );

    // RAM under test with a bit0 stuck-at-1 fault at address 2 and a read-corruption mask
    logic [DW-1:0] mem [4];
    logic          mem_clr, stuck_en;
    logic [DW-1:0] flip;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 4; i++) mem[i] <= '0;
            ram_rdata <= '0;
        end else begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            ram_rdata <= (mem[ram_addr] | ((stuck_en && ram_addr == 2) ? 8'h01 : 8'h00)) ^ flip;
        end
    end

    // Reference model: step number 0..STEPS (STEPS = finished), pending compare, flags
    int         m_step, m_p;
    bit         m_err, m_ce, m_pend, m_pend_last;
    logic [7:0] m_pend_exp;
    int         m_pend_addr, m_fa;
    int         checks = 0;
    int         failures = 0;
    int         ce_seen;

    function automatic logic [7:0] bg(input int p, input int a);
        case (p)
            1:       return 8'hFF;
            2:       return (a % 2 == 0) ? 8'h55 : 8'hAA;
            3:       return 8'(a);
            default: return 8'h00;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input bit r, input bit nc, input bit np, input bit rc, input bit rp,
                         input logic [7:0] fl);
        logic [7:0] rd;
        int         a;
        bit         mism, rdstep;
        rst = r; nxt_count = nc; nxt_pat = np; rst_count = rc; rst_pat = rp; flip = fl;
        @(negedge clk);
        a = (m_step < STEPS) ? m_step % 4 : 3;
        chk("ram_we", ram_we, (!r && nc && m_step < 4));
        chk("ram_addr", ram_addr, a);
        if (m_p < NP) chk("ram_wdata", ram_wdata, bg(m_p, a));
        chk("error", error, m_err);
        chk("count_end", count_end, m_ce);
        chk("pat_end", pat_end, (m_p == NP));
        chk("fail_addr", fail_addr, FA_EN ? m_fa : 0);
        if (count_end === 1'b1) ce_seen++;
        rd = ram_rdata;
        @(posedge clk);
        #1;
        if (r) begin
            m_step = 0; m_p = 0; m_err = 0; m_fa = 0; m_pend = 0; m_ce = 0;
        end else begin
            mism = m_pend && (rd !== m_pend_exp);
            if (rp) begin
                m_err = 0; m_fa = 0;
            end else if (mism && !m_err) begin
                m_err = 1; m_fa = m_pend_addr;
            end
            m_ce = m_pend && m_pend_last;
            rdstep = nc && !rc && m_step >= 4 && m_step < STEPS;
            m_pend = rdstep;
            if (rdstep) begin
                m_pend_exp  = bg(m_p, a);
                m_pend_addr = a;
                m_pend_last = (m_step == STEPS - 1);
            end
            if (rc) m_step = 0;
            else if (nc && m_step < STEPS) m_step++;
            if (rp) m_p = 0;
            else if (np && m_p < NP) m_p++;
        end
    endtask

    initial begin
        bit r, nc, np, rc, rp;
        logic [7:0] fl;
        rst = 1; rst_count = 0; rst_pat = 0; nxt_count = 0; nxt_pat = 0;
        flip = '0; stuck_en = 0; mem_clr = 1;
        m_step = 0; m_p = 0; m_err = 0; m_ce = 0; m_pend = 0; m_pend_last = 0;
        m_pend_exp = '0; m_pend_addr = 0; m_fa = 0; ce_seen = 0;
        repeat (2) @(posedge clk);
        #1;
        mem_clr = 0;

        // reset cycle with nxt_count high must not write
        cycle(1, 1, 0, 0, 0, 0);

        // four full patterns, extra nxt_count pulses after the last step of pattern 0
        for (int pp = 0; pp < NP; pp++) begin
            ce_seen = 0;
            repeat (STEPS) cycle(0, 1, 0, 0, 0, 0);
            repeat (3) cycle(0, (pp == 0), 0, 0, 0, 0);
            chk("count_end_once", ce_seen, 1);
            cycle(0, 0, 1, 1, 0, 0);
        end
        cycle(0, 0, 1, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        chk("pat_end_sat", pat_end, 1);

        // stuck-at fault at address 2, pattern 0
        cycle(0, 0, 0, 1, 1, 0);
        stuck_en = 1;
        repeat (STEPS) cycle(0, 1, 0, 0, 0, 0);
        repeat (2) cycle(0, 0, 0, 0, 0, 0);
        chk("stuck_error", error, 1);
        chk("stuck_fail_addr", fail_addr, FA_EN ? 2 : 0);
        cycle(0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        chk("error_after_rst_count", error, 1);
        cycle(0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0, 0);
        chk("error_after_rst_pat", error, 0);
        stuck_en = 0;

        // rst_count beats nxt_count at cnt=5
        repeat (5) cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 1, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        chk("rst_count_prio_addr", ram_addr, 0);

        // rst_pat beats nxt_pat at index 2
        cycle(0, 0, 1, 0, 0, 0);
        cycle(0, 0, 1, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        chk("pat2_wdata", ram_wdata, 8'h55);
        cycle(0, 0, 1, 0, 1, 0);
        cycle(0, 0, 0, 0, 0, 0);
        chk("rst_pat_prio_wdata", ram_wdata, 8'h00);

        // rst at step 3 of pattern 1
        cycle(0, 0, 1, 1, 0, 0);
        repeat (3) cycle(0, 1, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);

        // random control traffic with occasional read corruption
        repeat (800) begin
            r  = ($urandom_range(0, 199) == 0);
            nc = ($urandom_range(0, 3) != 0);
            np = (m_p < 3) && ($urandom_range(0, 39) == 0);
            rc = ($urandom_range(0, 29) == 0);
            rp = ($urandom_range(0, 49) == 0);
            fl = ($urandom_range(0, 19) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
            cycle(r, nc, np, rc, rp, fl);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
